// File: rtl/ex_stage_exmem.sv
// EX stage and EX/MEM pipeline register: single-cycle ALU plus an iterative 32-cycle
// shift-add multiplier that stalls the front end while it runs.
module ex_stage_exmem #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] a_ex,
    input  logic [31:0] b_ex,
    input  logic [31:0] imm_ex,
    input  logic [31:0] pc_ex,
    input  logic [4:0]  rw_ex,
    input  logic [3:0]  op_ex,
    input  logic        wreg_ex,
    input  logic        m2reg_ex,
    input  logic        wmem_ex,
    input  logic        aluimm_ex,
    input  logic        shift_ex,
    input  logic        jal_ex,
    input  logic        flush_ex,
    output logic        stall_ex,
    output logic [31:0] alu_mem,
    output logic [31:0] b_mem,
    output logic [4:0]  rw_mem,
    output logic        wreg_mem,
    output logic        m2reg_mem,
    output logic        wmem_mem
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     mcand_q, mcand_d;
    logic [31:0]     mplier_q, mplier_d;
    logic [31:0]     alu_mem_d, b_mem_d;
    logic [4:0]      rw_mem_d;
    logic            wreg_mem_d, m2reg_mem_d, wmem_mem_d;

    logic [31:0] srca, srcb, result;
    logic        mul_start;

    assign srca      = shift_ex ? {27'b0, imm_ex[10:6]} : a_ex;
    assign srcb      = aluimm_ex ? imm_ex : b_ex;
    assign mul_start = (state_q == StIdle) && (op_ex == 4'd11) && !jal_ex;
    // Flush aborts a multiply, so it must also release the stall in the same cycle.
    assign stall_ex  = reset_0 && !flush_ex && (mul_start || (state_q == StBusy));

    always_comb begin
        result = 32'b0;
        if (jal_ex) begin
            result = pc_ex + 32'd4;
        end else begin
            case (op_ex)
                4'd0:    result = srca + srcb;
                4'd1:    result = srca - srcb;
                4'd2:    result = srca & srcb;
                4'd3:    result = srca | srcb;
                4'd4:    result = srca ^ srcb;
                4'd5:    result = {srcb[15:0], 16'b0};
                4'd6:    result = srcb << srca[4:0];
                4'd7:    result = srcb >> srca[4:0];
                4'd8:    result = $unsigned($signed(srcb) >>> srca[4:0]);
                4'd9:    result = {31'b0, $signed(srca) < $signed(srcb)};
                4'd10:   result = {31'b0, srca < srcb};
                default: result = 32'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        alu_mem_d   = 32'b0;
        b_mem_d     = 32'b0;
        rw_mem_d    = 5'b0;
        wreg_mem_d  = 1'b0;
        m2reg_mem_d = 1'b0;
        wmem_mem_d  = 1'b0;
        if (flush_ex) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        mcand_d  = srca;
                        mplier_d = srcb;
                        acc_d    = 32'b0;
                        cnt_d    = '0;
                        state_d  = StBusy;
                    end else begin
                        alu_mem_d   = result;
                        b_mem_d     = b_ex;
                        rw_mem_d    = rw_ex;
                        wreg_mem_d  = wreg_ex;
                        m2reg_mem_d = m2reg_ex;
                        wmem_mem_d  = wmem_ex;
                    end
                end
                StBusy: begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CntLast) state_d = StDone;
                end
                StDone: begin
                    alu_mem_d   = acc_q;
                    b_mem_d     = b_ex;
                    rw_mem_d    = rw_ex;
                    wreg_mem_d  = wreg_ex;
                    m2reg_mem_d = m2reg_ex;
                    wmem_mem_d  = wmem_ex;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= 32'b0;
            mcand_q   <= 32'b0;
            mplier_q  <= 32'b0;
            alu_mem   <= 32'b0;
            b_mem     <= 32'b0;
            rw_mem    <= 5'b0;
            wreg_mem  <= 1'b0;
            m2reg_mem <= 1'b0;
            wmem_mem  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            alu_mem   <= alu_mem_d;
            b_mem     <= b_mem_d;
            rw_mem    <= rw_mem_d;
            wreg_mem  <= wreg_mem_d;
            m2reg_mem <= m2reg_mem_d;
            wmem_mem  <= wmem_mem_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Bench for ex_stage_exmem: directed cases plus random instructions checked against an
// arithmetic reference model.
module tb_ex_stage_exmem;

    logic        clock = 1'b0;
    logic        reset_0;
    logic [31:0] a_ex, b_ex, imm_ex, pc_ex;
    logic [4:0]  rw_ex;
    logic [3:0]  op_ex;
    logic        wreg_ex, m2reg_ex, wmem_ex, aluimm_ex, shift_ex, jal_ex, flush_ex;
    logic        stall_ex;
    logic [31:0] alu_mem, b_mem;
    logic [4:0]  rw_mem;
    logic        wreg_mem, m2reg_mem, wmem_mem;

    int total = 0;
    int bad   = 0;

    ex_stage_exmem #(.MUL_CYCLES(32)) dut (
        .clock(clock), .reset_0(reset_0),
        .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex), .pc_ex(pc_ex), .rw_ex(rw_ex),
        .op_ex(op_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex), .wmem_ex(wmem_ex),
        .aluimm_ex(aluimm_ex), .shift_ex(shift_ex), .jal_ex(jal_ex), .flush_ex(flush_ex),
        .stall_ex(stall_ex), .alu_mem(alu_mem), .b_mem(b_mem), .rw_mem(rw_mem),
        .wreg_mem(wreg_mem), .m2reg_mem(m2reg_mem), .wmem_mem(wmem_mem)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result();
        logic [31:0] sa, sb;
        logic [63:0] prod;
        int n;
        sa = shift_ex ? {27'b0, imm_ex[10:6]} : a_ex;
        sb = aluimm_ex ? imm_ex : b_ex;
        n  = int'(sa % 32);
        if (jal_ex) return pc_ex + 32'd4;
        case (op_ex)
            4'd0:  return sa + sb;
            4'd1:  return sa + ~sb + 32'd1;
            4'd2:  return sa & sb;
            4'd3:  return sa | sb;
            4'd4:  return sa ^ sb;
            4'd5:  return sb * 32'd65536;
            4'd6:  return sb << n;
            4'd7:  return sb >> n;
            4'd8:  return (sb >> n) | (sb[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
            4'd9:  return (int'(sa) < int'(sb)) ? 32'd1 : 32'd0;
            4'd10: return (longint'({32'b0, sa}) < longint'({32'b0, sb})) ? 32'd1 : 32'd0;
            4'd11: begin
                prod = {32'b0, sa} * {32'b0, sb};
                return prod[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [3:0] op, input logic [4:0] rw, input logic [5:0] ctl);
        a_ex = a; b_ex = b; imm_ex = imm; op_ex = op; rw_ex = rw;
        {wreg_ex, m2reg_ex, wmem_ex, aluimm_ex, shift_ex, jal_ex} = ctl;
        #1;
    endtask

    // Inputs already presented; checks a one-edge instruction.
    task automatic expect_single(input string tag);
        logic [31:0] exp;
        exp = ref_result();
        check({tag, "_stall"}, {31'b0, stall_ex}, 32'd0);
        tick();
        check({tag, "_alu"}, alu_mem, exp);
        check({tag, "_ctl"}, {b_mem[15:0], 3'b0, rw_mem, 5'b0, wreg_mem, m2reg_mem, wmem_mem},
              {b_ex[15:0], 3'b0, rw_ex, 5'b0, wreg_ex, m2reg_ex, wmem_ex});
    endtask

    // Inputs already presented and held; 33 stall cycles then result on the 34th edge.
    task automatic expect_mul(input string tag);
        logic [31:0] exp;
        int stalls;
        exp = ref_result();
        stalls = 0;
        for (int i = 0; i < 34; i++) begin
            if (stall_ex) stalls++;
            tick();
            if (i < 33) begin
                if (wreg_mem || wmem_mem || m2reg_mem || alu_mem != 0)
                    check({tag, "_bubble"}, {alu_mem[28:0], wreg_mem, m2reg_mem, wmem_mem}, 32'd0);
            end
        end
        check({tag, "_stalls"}, stalls, 32'd33);
        check({tag, "_alu"}, alu_mem, exp);
        check({tag, "_ctl"}, {27'b0, rw_mem}, {27'b0, rw_ex});
        check({tag, "_wreg"}, {31'b0, wreg_mem}, {31'b0, wreg_ex});
    endtask

    initial begin
        reset_0 = 1'b0; flush_ex = 1'b0; pc_ex = 32'h0;
        set_op(0, 0, 0, 0, 0, 6'b0);
        check("reset_stall", {31'b0, stall_ex}, 32'd0);
        check("reset_outs", {alu_mem[15:0], b_mem[7:0], rw_mem, wreg_mem, m2reg_mem, wmem_mem},
              32'd0);
        repeat (2) tick();
        reset_0 = 1'b1;
        tick();

        // ADD immediate
        set_op(32'd5, 32'd0, 32'hFFFF_FFFE, 4'd0, 5'd3, 6'b100100);
        expect_single("add_imm");
        check("add_imm_val", alu_mem, 32'd3);

        // SRA by shamt field, SLT and SLTU
        set_op(32'd0, 32'h8000_0000, 32'd4 << 6, 4'd8, 5'd4, 6'b100010);
        expect_single("sra");
        check("sra_val", alu_mem, 32'hF800_0000);
        set_op(32'hFFFF_FFFF, 32'd1, 32'd0, 4'd9, 5'd5, 6'b100000);
        expect_single("slt");
        check("slt_val", alu_mem, 32'd1);
        set_op(32'hFFFF_FFFF, 32'd1, 32'd0, 4'd10, 5'd5, 6'b100000);
        expect_single("sltu");
        check("sltu_val", alu_mem, 32'd0);

        // JAL overrides op
        pc_ex = 32'h0040_0010;
        set_op(32'd7, 32'd9, 32'd0, 4'd3, 5'd31, 6'b100001);
        expect_single("jal");
        check("jal_val", alu_mem, 32'h0040_0014);

        // MUL then back-to-back ADD
        set_op(32'h0001_2345, 32'h0000_1000, 32'd0, 4'd11, 5'd7, 6'b100000);
        check("mul_start_stall", {31'b0, stall_ex}, 32'd1);
        expect_mul("mul");
        check("mul_val", alu_mem, 32'h1234_5000);
        set_op(32'd10, 32'd20, 32'd0, 4'd0, 5'd8, 6'b100000);
        expect_single("b2b_add");

        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd11, 5'd9, 6'b100000);
        expect_mul("mul_wrap");
        check("mul_wrap_val", alu_mem, 32'd1);

        // Flush at BUSY counter 10 (11 edges after the MUL first presents)
        set_op(32'd3, 32'd5, 32'd0, 4'd11, 5'd2, 6'b101000);
        repeat (11) tick();
        check("pre_flush_stall", {31'b0, stall_ex}, 32'd1);
        flush_ex = 1'b1;
        #1;
        check("flush_stall", {31'b0, stall_ex}, 32'd0);
        tick();
        flush_ex = 1'b0;
        check("flush_bubble", {alu_mem[28:0], wreg_mem, m2reg_mem, wmem_mem}, 32'd0);
        set_op(32'd100, 32'd1, 32'd0, 4'd1, 5'd6, 6'b100000);
        expect_single("post_flush");

        // Async reset: clears a live result, and aborts a multiply
        reset_0 = 1'b0;
        #1;
        check("async_rst_alu", alu_mem, 32'd0);
        check("async_rst_wreg", {31'b0, wreg_mem}, 32'd0);
        reset_0 = 1'b1;
        set_op(32'd6, 32'd7, 32'd0, 4'd11, 5'd1, 6'b100000);
        repeat (6) tick();
        reset_0 = 1'b0;
        #1;
        check("rst_mid_stall", {31'b0, stall_ex}, 32'd0);
        check("rst_mid_outs", {alu_mem[26:0], rw_mem}, 32'd0);
        tick();
        reset_0 = 1'b1;
        set_op(32'd6, 32'd7, 32'd0, 4'd2, 5'd1, 6'b100000);
        expect_single("post_rst");
        for (int i = 0; i < 40; i++) begin
            tick();
            check("no_stale", {31'b0, wreg_mem}, {31'b0, 1'b1});
            if (alu_mem != 32'd6) check("no_stale_alu", alu_mem, 32'd6);
        end

        // Random instructions
        for (int i = 0; i < 60; i++) begin
            pc_ex = $urandom & 32'hFFFF_FFFC;
            set_op($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                   5'($urandom), 6'($urandom) & (($urandom_range(0, 7) == 0) ? 6'h3F : 6'h3E));
            if (op_ex == 4'd11 && !jal_ex) expect_mul("rnd_mul");
            else expect_single("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_exmem.md
Name: ex_stage_exmem

Overview:
- Consumer end of the ID->EX pipeline register: takes the *_ex fields, performs the EX-stage operation and registers results into the EX->MEM boundary.
- Adds an iterative 32-cycle shift-add multiplier.
- Raises stall_ex so the ID->EX register and earlier stages hold while a multiply is in flight.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- MUL_CYCLES, 32, multiplier iterations (one operand bit per cycle); fixed at 32 for the 32-bit datapath.

Ports:
- clock  in  1  rising-edge clock
- reset_0  in  1  asynchronous, active-low reset
- a_ex, b_ex, imm_ex, pc_ex  in  32 each  operands, sign-extended immediate, instruction PC
- rw_ex  in  5  destination register
- op_ex  in  4  ALU operation
- wreg_ex, m2reg_ex, wmem_ex, aluimm_ex, shift_ex, jal_ex  in  1 each  control bits from ID/EX
- flush_ex  in  1  squash the instruction currently in EX
- stall_ex  out  1  hold the ID/EX register and upstream stages this cycle
- alu_mem  out  32  registered result
- b_mem  out  32  registered store data (b_ex)
- rw_mem  out  5  registered destination
- wreg_mem, m2reg_mem, wmem_mem  out  1 each  registered controls

Behaviour:
- Reset (reset_0=0, async): all *_mem outputs 0; FSM to IDLE; counter, accumulator and multiplicand 0; stall_ex 0.
- Operand select:
  - srca = shift_ex ? {27'b0, imm_ex[10:6]} : a_ex
  - srcb = aluimm_ex ? imm_ex : b_ex
- op_ex encoding, combinational result, all mod 2^32:
  - 0 ADD srca+srcb
  - 1 SUB srca-srcb
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 LUI {srcb[15:0], 16'b0}
  - 6 SLL srcb<<srca[4:0]
  - 7 SRL logical
  - 8 SRA arithmetic
  - 9 SLT signed, result 1/0
  - 10 SLTU unsigned, result 1/0
  - 11 MUL, low 32 bits of unsigned srca*srcb, multi-cycle
  - 12-15 result 0
- jal_ex=1 overrides op_ex: result = pc_ex + 4.
- Single-cycle ops: 1-cycle latency. At the next rising edge the EX/MEM outputs take the result, b_ex, rw_ex, wreg_ex, m2reg_ex, wmem_ex.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE, op_ex=11, jal_ex=0, flush_ex=0:
    - stall_ex=1 combinationally.
    - Edge: latch multiplicand=srca and multiplier=srcb, clear accumulator and counter, go to BUSY.
    - EX/MEM receives a bubble (wreg/m2reg/wmem=0; alu_mem, rw_mem, b_mem=0).
  - BUSY:
    - stall_ex=1.
    - Each edge: if multiplier[0], accumulator += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
    - counter==MUL_CYCLES-1 at the edge -> DONE.
    - EX/MEM receives a bubble.
  - DONE:
    - stall_ex=0.
    - Edge: EX/MEM captures alu_mem=accumulator plus the (held) rw_ex and control bits; go to IDLE.
  - Totals: 33 stall cycles; MUL result appears at alu_mem 34 edges after MUL first presents in EX.
- ID/EX contents are held stable by upstream throughout stall_ex=1; the block does not re-sample operands after the IDLE load.
- flush_ex=1, any state: at the edge EX/MEM takes a bubble and the FSM goes to IDLE. stall_ex is 0 in that cycle, which aborts any multiply in progress. flush has priority over MUL start and DONE capture.
- reset_0 asserted mid-multiply: immediate abort to the reset state; no partial result is emitted.
- Bubbles never assert wreg_mem or wmem_mem.
- Overflow: ADD, SUB and MUL wrap silently; no exception output.

Test Plan:
- ADD imm: a_ex=5, imm_ex=0xFFFFFFFE, aluimm_ex=1, op=0, rw=3, wreg=1 -> next edge alu_mem=3, rw_mem=3, wreg_mem=1, stall_ex stays 0.
- Shift/SRA and SLT: shift_ex=1, imm_ex[10:6]=4, b_ex=0x80000000, op=8 -> alu_mem=0xF8000000. Separately a=-1, b=1, op=9 -> 1; same operands with op=10 -> 0.
- JAL: pc_ex=0x00400010, jal_ex=1, op=3, rw=31 -> alu_mem=0x00400014, rw_mem=31.
- MUL: a_ex=0x00012345, b_ex=0x00001000, op=11, wreg=1, held stable ->
  - stall_ex high for exactly 33 cycles;
  - wreg_mem=0 during those cycles;
  - then alu_mem=0x12345000, wreg_mem=1;
  - back-to-back ADD completes on the following edge.
- MUL wrap: a=b=0xFFFFFFFF -> alu_mem=0x00000001 after 34 edges.
- Abort:
  - flush_ex pulsed at BUSY counter=10 -> stall_ex drops that cycle, bubble emitted, FSM IDLE.
  - reset_0 low mid-BUSY -> all outputs 0 asynchronously, no stale result after release.
